// File: rtl/grid_ring_renderer.sv
// Animated ring painter for the game grid: draws a ring in every cell holding MARK_CODE,
// grows it one pixel per frame and blinks rings in winning cells between two colours.
module grid_ring_renderer #(
  parameter int         GRID_N       = 3,
  parameter int         ORIGIN_X     = 15,
  parameter int         ORIGIN_Y     = 9,
  parameter int         PITCH_X      = 33,
  parameter int         PITCH_Y      = 22,
  parameter int         R_OUT        = 7,
  parameter int         R_IN         = 4,
  parameter logic [1:0] MARK_CODE    = 2'b10,
  parameter bit         ANIM         = 1'b1,
  parameter int         BLINK_FRAMES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic [6:0]                   x,
  input  logic [5:0]                   y,
  input  logic [2*GRID_N*GRID_N-1:0]   grid_data,
  input  logic [GRID_N*GRID_N-1:0]     win_mask,
  input  logic [15:0]                  color_hex,
  input  logic [15:0]                  win_color,
  output logic [15:0]                  oled_data,
  output logic                         pix_hit
);

  localparam int NC = GRID_N * GRID_N;
  localparam int SW = $clog2(R_OUT + 1);
  localparam int DW = 12;
  localparam int QW = 2 * DW;

  localparam logic [SW-1:0] RMAX  = SW'(R_OUT);
  localparam logic [SW-1:0] RGAP  = SW'(R_OUT - R_IN);
  localparam logic [7:0]    BLAST = 8'(BLINK_FRAMES - 1);

  logic [SW-1:0] stage [NC];
  logic [7:0]    bcnt;
  logic          phase;
  logic [NC-1:0] hit;
  logic          any_hit;
  logic          hit_win;
  logic [15:0]   pix_color;

  // Per-cell hit test; centres are elaboration-time constants so only the
  // pixel differences and the squares are real hardware.
  for (genvar k = 0; k < NC; k++) begin : g_cell
    localparam logic signed [DW-1:0] CX = DW'(ORIGIN_X + (k % GRID_N) * PITCH_X);
    localparam logic signed [DW-1:0] CY = DW'(ORIGIN_Y + (k / GRID_N) * PITCH_Y);

    logic [1:0]           code;
    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [QW-1:0] dxe;
    logic signed [QW-1:0] dye;
    logic [QW-1:0]        d2;
    logic [SW-1:0]        ri;
    logic [QW-1:0]        ro_ext;
    logic [QW-1:0]        ri_ext;
    logic [QW-1:0]        ro2;
    logic [QW-1:0]        ri2;

    assign code   = grid_data[2*k +: 2];
    assign dx     = $signed({{(DW-7){1'b0}}, x}) - CX;
    assign dy     = $signed({{(DW-6){1'b0}}, y}) - CY;
    assign dxe    = {{DW{dx[DW-1]}}, dx};
    assign dye    = {{DW{dy[DW-1]}}, dy};
    assign d2     = dxe * dxe + dye * dye;
    assign ri     = (stage[k] > RGAP) ? stage[k] - RGAP : '0;
    assign ro_ext = {{(QW-SW){1'b0}}, stage[k]};
    assign ri_ext = {{(QW-SW){1'b0}}, ri};
    assign ro2    = ro_ext * ro_ext;
    assign ri2    = ri_ext * ri_ext;

    // The live code gates drawing, so a cleared cell vanishes before its stage resets.
    assign hit[k] = (code == MARK_CODE) && (stage[k] != '0) && (d2 >= ri2) && (d2 <= ro2);
  end

  // Highest-index hitting cell wins when rings overlap.
  always_comb begin
    any_hit = 1'b0;
    hit_win = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (hit[k]) begin
        any_hit = 1'b1;
        hit_win = win_mask[k];
      end
    end
    if (!any_hit) begin
      pix_color = 16'h0000;
    end else if (hit_win && phase) begin
      pix_color = win_color;
    end else begin
      pix_color = color_hex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oled_data <= 16'h0000;
      pix_hit   <= 1'b0;
    end else begin
      oled_data <= pix_color;
      pix_hit   <= any_hit;
    end
  end

  // Stage counters only move on frame ticks and saturate at the full radius.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) begin
        stage[k] <= '0;
      end
    end else if (frame_tick) begin
      for (int k = 0; k < NC; k++) begin
        if (grid_data[2*k +: 2] != MARK_CODE) begin
          stage[k] <= '0;
        end else if (!ANIM) begin
          stage[k] <= RMAX;
        end else if (stage[k] < RMAX) begin
          stage[k] <= stage[k] + 1'b1;
        end
      end
    end
  end

  // Blink timer restarts from a known phase whenever there is no winning line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= 8'd0;
      phase <= 1'b0;
    end else if (win_mask == '0) begin
      bcnt  <= 8'd0;
      phase <= 1'b0;
    end else if (frame_tick) begin
      if (bcnt >= BLAST) begin
        bcnt  <= 8'd0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 8'd1;
      end
    end
  end

endmodule
